mem_port_scheduler: RTL and testbench

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

---
 rtl/mem_port_scheduler_if.sv | 42 ++++
 rtl/mem_port_scheduler.sv | 148 ++++++++++++++
 tb/tb_mem_port_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_scheduler_if.sv
// Bundles the store-queue, load-request and data-memory signals of the scheduler.
// The slave modport is the scheduler side, the master modport the environment side.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

interface mem_port_scheduler_if #(
  parameter int L  = 8,
  parameter int RW = $clog2(`NUM_D_REG)
);
  logic              st_valid;
  logic              st_ready;
  logic              sq_push;
  logic              sq_pop;
  logic [15:0]       sq_head_addr;
  logic [15:0]       sq_head_data;
  logic [$clog2(L):0] sq_count;
  logic              ld_valid;
  logic [15:0]       ld_addr;
  logic [RW-1:0]     ld_reg;
  logic              ld_ready;
  logic              mem_en;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_wdata;
  logic              ld_done;
  logic [RW-1:0]     ld_done_reg;
  logic              drain;
  logic              drain_done;

  modport slave (
    input  st_valid, sq_head_addr, sq_head_data, ld_valid, ld_addr, ld_reg, drain,
    output st_ready, sq_push, sq_pop, sq_count, ld_ready, mem_en, mem_we,
           mem_addr, mem_wdata, ld_done, ld_done_reg, drain_done
  );

  modport master (
    output st_valid, sq_head_addr, sq_head_data, ld_valid, ld_addr, ld_reg, drain,
    input  st_ready, sq_push, sq_pop, sq_count, ld_ready, mem_en, mem_we,
           mem_addr, mem_wdata, ld_done, ld_done_reg, drain_done
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// Arbitrates a single data-memory port between a store queue and a load stream,
// with head-address ordering, store-starvation limit and forced drain.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

module mem_port_scheduler #(
  parameter int L          = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  mem_port_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(L) + 1;
  localparam int REG_W = $clog2(`NUM_D_REG);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam bit MULTI = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(L);
  localparam logic [LAT_W-1:0] BUSY_INIT = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [LAT_W-1:0] LD_INIT   = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 1) : 0);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [LAT_W-1:0]   r_busy_cnt, w_busy_cnt_nxt;
  logic [CNT_W-1:0]   r_sq_count;
  logic [STV_W-1:0]   r_starve;
  logic               r_ld_pend;
  logic [LAT_W-1:0]   r_ld_left;
  logic [REG_W-1:0]   r_ld_reg;
  logic               r_ld_done;
  logic [REG_W-1:0]   r_ld_done_reg;

  logic               w_idle, w_nonempty, w_full, w_st_pref;
  logic               w_st_issue, w_ld_issue, w_push, w_ld_fire;
  logic [REG_W-1:0]   w_fire_reg;

  assign w_idle     = (r_state == S_IDLE);
  assign w_nonempty = (r_sq_count != {CNT_W{1'b0}});
  assign w_full     = (r_sq_count == FULL);
  // A store wins whenever waiting would be unsafe or pointless for it.
  assign w_st_pref  = bus.drain | w_full | (r_starve == STV_MAX) | ~bus.ld_valid
                    | (bus.ld_addr == bus.sq_head_addr);
  assign w_push     = n_rst & bus.st_valid & ~w_full;
  assign w_ld_fire  = MULTI ? (r_ld_pend && (r_ld_left == LAT_W'(1))) : w_ld_issue;
  assign w_fire_reg = MULTI ? r_ld_reg : bus.ld_reg;

  assign bus.st_ready    = ~n_rst | ~w_full;
  assign bus.sq_push     = w_push;
  assign bus.sq_pop      = w_st_issue;
  assign bus.sq_count    = r_sq_count;
  assign bus.ld_ready    = w_ld_issue;
  assign bus.mem_en      = w_st_issue | w_ld_issue;
  assign bus.mem_we      = w_st_issue;
  assign bus.mem_addr    = w_st_issue ? bus.sq_head_addr : (w_ld_issue ? bus.ld_addr : 16'h0000);
  assign bus.mem_wdata   = w_st_issue ? bus.sq_head_data : 16'h0000;
  assign bus.ld_done     = n_rst & r_ld_done;
  assign bus.ld_done_reg = r_ld_done_reg;
  assign bus.drain_done  = n_rst & bus.drain & ~w_nonempty & w_idle;

  // FSM next state and issue decision
  always_comb begin
    w_st_issue     = 1'b0;
    w_ld_issue     = 1'b0;
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    case (r_state)
      S_IDLE: begin
        if (n_rst && w_nonempty && w_st_pref) w_st_issue = 1'b1;
        else if (n_rst && bus.ld_valid)       w_ld_issue = 1'b1;
        else                                  w_ld_issue = 1'b0;
        if ((w_st_issue || w_ld_issue) && MULTI) begin
          w_state_nxt    = S_BUSY;
          w_busy_cnt_nxt = BUSY_INIT;
        end else begin
          w_state_nxt    = S_IDLE;
          w_busy_cnt_nxt = {LAT_W{1'b0}};
        end
      end
      S_BUSY: begin
        if (r_busy_cnt == {LAT_W{1'b0}}) w_state_nxt = S_IDLE;
        else                             w_busy_cnt_nxt = r_busy_cnt - LAT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_busy_cnt <= {LAT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  // Store-queue occupancy
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_sq_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_st_issue})
        2'b10:   r_sq_count <= r_sq_count + CNT_W'(1);
        2'b01:   r_sq_count <= r_sq_count - CNT_W'(1);
        default: r_sq_count <= r_sq_count;
      endcase
    end
  end

  // Count loads that overtook a waiting store
  always_ff @(posedge clk) begin
    if (!n_rst)                              r_starve <= {STV_W{1'b0}};
    else if (!w_nonempty || w_st_issue)      r_starve <= {STV_W{1'b0}};
    else if (w_ld_issue && r_starve != STV_MAX) r_starve <= r_starve + STV_W'(1);
    else                                     r_starve <= r_starve;
  end

  // Track the single in-flight load and report its completion
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ld_pend     <= 1'b0;
      r_ld_left     <= {LAT_W{1'b0}};
      r_ld_reg      <= {REG_W{1'b0}};
      r_ld_done     <= 1'b0;
      r_ld_done_reg <= {REG_W{1'b0}};
    end else begin
      r_ld_done <= w_ld_fire;
      if (w_ld_fire) r_ld_done_reg <= w_fire_reg;
      else           r_ld_done_reg <= r_ld_done_reg;
      if (w_ld_issue) begin
        r_ld_pend <= MULTI;
        r_ld_left <= LD_INIT;
        r_ld_reg  <= bus.ld_reg;
      end else if (r_ld_pend) begin
        r_ld_left <= r_ld_left - LAT_W'(1);
        r_ld_pend <= (r_ld_left != LAT_W'(1));
      end else begin
        r_ld_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: a queue/time-based reference model checked
// every cycle, plus literal expectations for the characteristic scenarios.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

module tb_mem_port_scheduler;
  localparam int L  = 8;
  localparam int ML = 2;
  localparam int SM = 4;
  localparam int RW = $clog2(`NUM_D_REG);

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  mem_port_scheduler_if #(.L(L), .RW(RW)) bus ();
  mem_port_scheduler_if #(.L(L), .RW(RW)) bus3 ();

  mem_port_scheduler #(.L(L), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus));
  mem_port_scheduler #(.L(L), .MEM_LAT(3), .STARVE_MAX(SM)) dut3 (
    .clk(clk), .n_rst(n_rst), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  // environment store queue (also the model's queue) and model state
  int q_addr[$];
  int q_data[$];
  int pd_cyc[$];
  int pd_reg[$];
  int cyc = 0;
  int free_at = 0;
  int starve = 0;
  int last_reg = 0;
  bit model_ok = 1'b0;
  int seq = 0;
  logic [15:0] tb_st_addr, tb_st_data;
  logic l3_valid;
  logic [RW-1:0] l3_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sv, input logic lv, input logic [15:0] la,
                      input logic [RW-1:0] lr, input logic dr, input logic rn, input int sa);
    @(negedge clk);
    n_rst            = rn;
    bus.st_valid     = sv;
    bus.ld_valid     = lv;
    bus.ld_addr      = la;
    bus.ld_reg       = lr;
    bus.drain        = dr;
    bus.sq_head_addr = (q_addr.size() > 0) ? 16'(q_addr[0]) : 16'h0000;
    bus.sq_head_data = (q_data.size() > 0) ? 16'(q_data[0]) : 16'h0000;
    tb_st_addr       = (sa >= 0) ? 16'(sa) : 16'(32'h1000 + seq);
    tb_st_data       = 16'(32'hA000 + seq);
    seq++;
    bus3.ld_valid    = l3_valid;
    bus3.ld_reg      = l3_reg;
    #1;
  endtask

  // reference model and per-cycle comparison
  always @(negedge clk) begin : cmp_p
    int cnt, head_a, head_d, exp_addr, exp_wd;
    bit idle, ready, push, pref, st_iss, ld_iss, done;
    #2;
    cnt  = q_addr.size();
    done = (pd_cyc.size() > 0) && (pd_cyc[0] == cyc);
    if (done) begin
      last_reg = pd_reg[0];
      void'(pd_cyc.pop_front());
      void'(pd_reg.pop_front());
    end
    if (!n_rst) begin
      if (model_ok) begin
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_sq_pop", bus.sq_pop, 0);
        chk("rst_sq_push", bus.sq_push, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_ld_done", bus.ld_done, 0);
        chk("rst_drain_done", bus.drain_done, 0);
        chk("rst_st_ready", bus.st_ready, 1);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_sq_count", bus.sq_count, cnt);
        chk("rst_ld_done_reg", bus.ld_done_reg, last_reg);
      end
      q_addr.delete(); q_data.delete(); pd_cyc.delete(); pd_reg.delete();
      starve = 0; free_at = cyc + 1; last_reg = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      head_a = 0; head_d = 0;
      if (cnt > 0) begin head_a = q_addr[0]; head_d = q_data[0]; end
      idle   = (cyc >= free_at);
      ready  = (cnt < L);
      push   = bus.st_valid && ready;
      pref   = bus.drain || (cnt == L) || (starve == SM) || !bus.ld_valid
               || (int'(bus.ld_addr) == head_a);
      st_iss = idle && (cnt > 0) && pref;
      ld_iss = idle && !st_iss && bus.ld_valid;
      exp_addr = st_iss ? head_a : (ld_iss ? int'(bus.ld_addr) : 0);
      exp_wd   = st_iss ? head_d : 0;
      chk("mem_en", bus.mem_en, st_iss || ld_iss);
      chk("mem_we", bus.mem_we, st_iss);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, exp_wd);
      chk("sq_pop", bus.sq_pop, st_iss);
      chk("ld_ready", bus.ld_ready, ld_iss);
      chk("st_ready", bus.st_ready, ready);
      chk("sq_push", bus.sq_push, push);
      chk("sq_count", bus.sq_count, cnt);
      chk("ld_done", bus.ld_done, done);
      chk("ld_done_reg", bus.ld_done_reg, last_reg);
      chk("drain_done", bus.drain_done, bus.drain && cnt == 0 && idle);
      if (cnt == 0 || st_iss) starve = 0;
      else if (ld_iss && starve < SM) starve++;
      if (st_iss) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        free_at = cyc + ML;
      end
      if (ld_iss) begin
        free_at = cyc + ML;
        pd_cyc.push_back(cyc + ML);
        pd_reg.push_back(int'(bus.ld_reg));
      end
      if (push) begin
        q_addr.push_back(int'(tb_st_addr));
        q_data.push_back(int'(tb_st_data));
      end
    end
    cyc++;
  end

  initial begin
    int grants, pops, wes;
    n_rst = 1'b0;
    bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = 16'h0000;
    bus.ld_reg = '0; bus.drain = 1'b0;
    bus.sq_head_addr = 16'h0000; bus.sq_head_data = 16'h0000;
    bus3.st_valid = 1'b0; bus3.ld_valid = 1'b0; bus3.ld_addr = 16'h0120;
    bus3.ld_reg = '0; bus3.drain = 1'b0;
    bus3.sq_head_addr = 16'h0000; bus3.sq_head_data = 16'h0000;
    l3_valid = 1'b0; l3_reg = '0;

    // reset state
    step(0, 0, 16'h0, 0, 0, 0, -1);
    step(0, 0, 16'h0, 0, 0, 0, -1);
    chk("lit_rst_st_ready", bus.st_ready, 1);
    chk("lit_rst_mem_en", bus.mem_en, 0);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("lit_post_rst_count", bus.sq_count, 0);
    chk("lit_post_rst_done_reg", bus.ld_done_reg, 0);

    // MEM_LAT=3 load completion timing
    l3_valid = 1'b1; l3_reg = 5;
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("lat3_issue_ready", bus3.ld_ready, 1);
    chk("lat3_issue_en", bus3.mem_en, 1);
    chk("lat3_issue_addr", bus3.mem_addr, 16'h0120);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 16'h0, 0, 0, 1, -1);
      chk("lat3_busy_en", bus3.mem_en, 0);
      chk("lat3_busy_ready", bus3.ld_ready, 0);
      chk("lat3_busy_done", bus3.ld_done, 0);
    end
    l3_valid = 1'b0;
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("lat3_done", bus3.ld_done, 1);
    chk("lat3_done_reg", bus3.ld_done_reg, 5);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("lat3_done_once", bus3.ld_done, 0);
    chk("lat3_done_reg_hold", bus3.ld_done_reg, 5);

    // fill the queue with stores only, then drain it
    for (int i = 0; i < 15; i++) step(1, 0, 16'h0, 0, 0, 1, -1);
    step(1, 0, 16'h0, 0, 0, 1, -1);
    chk("full_st_ready", bus.st_ready, 0);
    chk("full_count", bus.sq_count, 8);
    chk("full_no_push", bus.sq_push, 0);
    chk("full_pop", bus.sq_pop, 1);
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 16'h0, 0, 0, 1, -1);
      pops += int'(bus.sq_pop);
    end
    chk("empty_count", bus.sq_count, 0);
    chk("empty_pops", pops, 7);

    // starvation limit: four loads, then the waiting store
    step(1, 0, 16'h0, 0, 0, 1, -1);
    grants = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 16'h0300, RW'(i), 0, 1, -1);
      if (i < 8) grants += int'(bus.ld_ready);
      else begin
        chk("starve_store_we", bus.mem_we, 1);
        chk("starve_store_pop", bus.sq_pop, 1);
        chk("starve_store_noload", bus.ld_ready, 0);
      end
    end
    chk("starve_grants", grants, 4);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    step(0, 0, 16'h0, 0, 0, 1, -1);

    // load hitting the queue head waits behind that store
    step(1, 0, 16'h0, 0, 0, 1, 32'h0040);
    step(0, 1, 16'h0040, 7, 0, 1, -1);
    chk("hazard_store_we", bus.mem_we, 1);
    chk("hazard_store_addr", bus.mem_addr, 16'h0040);
    chk("hazard_no_load", bus.ld_ready, 0);
    step(0, 1, 16'h0040, 7, 0, 1, -1);
    chk("hazard_busy", bus.mem_en, 0);
    step(0, 1, 16'h0040, 7, 0, 1, -1);
    chk("hazard_load", bus.ld_ready, 1);
    chk("hazard_load_we", bus.mem_we, 0);
    chk("hazard_load_addr", bus.mem_addr, 16'h0040);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    step(0, 0, 16'h0, 0, 0, 1, -1);

    // drain with three stores queued and loads pending
    step(1, 1, 16'h0500, 1, 0, 1, -1);
    step(1, 1, 16'h0500, 1, 0, 1, -1);
    step(1, 1, 16'h0500, 1, 0, 1, -1);
    step(0, 1, 16'h0500, 1, 0, 1, -1);
    chk("drain_pre_count", bus.sq_count, 3);
    grants = 0; wes = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 16'h0500, 2, 1, 1, -1);
      if (i < 6) begin
        grants += int'(bus.ld_ready);
        wes    += int'(bus.mem_we);
      end
      if (i == 5) chk("drain_done_busy", bus.drain_done, 0);
      if (i == 6) chk("drain_done_idle", bus.drain_done, 1);
    end
    chk("drain_no_loads", grants, 0);
    chk("drain_stores", wes, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 0, 1, -1);

    // reset right after a load issue abandons it
    step(1, 1, 16'h0600, 3, 0, 1, -1);
    chk("rst_abandon_issue", bus.ld_ready, 1);
    step(1, 0, 16'h0, 0, 0, 0, -1);
    chk("rst_abandon_nopush", bus.sq_push, 0);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("rst_abandon_no_done", bus.ld_done, 0);
    chk("rst_abandon_count", bus.sq_count, 0);
    chk("rst_abandon_ready", bus.st_ready, 1);
    step(0, 0, 16'h0, 0, 0, 1, -1);
    chk("rst_abandon_no_done2", bus.ld_done, 0);
    step(0, 0, 16'h0, 0, 0, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
